// File: rtl/spi_pkg.sv
// Shared SPI types and constants for the master, the slave and their benches.
package spi_pkg;

   localparam int CPOL_BIT       = 1;
   localparam int CPHA_BIT       = 0;
   localparam int DEFAULT_DATA_W = 8;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SHIFT,
      TRAIL,
      DONE
   } spi_state_t;

endpackage

// File: rtl/spi_master_if.sv
// Host-side request/response and SPI pin bundle for spi_master.
interface spi_master_if #(
   parameter int DATA_W = spi_pkg::DEFAULT_DATA_W
);
   logic [1:0]        mode;
   logic [DATA_W-1:0] master_in;
   logic              start;
   logic              miso;
   logic              sclk;
   logic              mosi;
   logic              ss;
   logic [DATA_W-1:0] master_data;
   logic              busy;
   logic              done;

   modport master (
      input  mode, master_in, start, miso,
      output sclk, mosi, ss, master_data, busy, done
   );

   modport slave (
      output mode, master_in, start, miso,
      input  sclk, mosi, ss, master_data, busy, done
   );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period timer for sclk: down-counter reloading at terminal count.
module spi_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt <= LOAD;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (en) begin
         cnt <= (cnt == '0) ? LOAD : cnt - 1'b1;
      end
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Full-duplex MSB-first SPI master, all four modes, one word per start.
//  state | meaning
//  IDLE  | ss high, sclk parked at latched CPOL, waiting for start
//  LEAD  | ss low, one half-period of setup before the first edge
//  SHIFT | 2*DATA_W sclk edges; sample and advance per CPHA
//  TRAIL | one half-period of ss hold, sclk back at CPOL
//  DONE  | single cycle: publish received word, pulse done
module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int CLK_DIV = 2
) (
   input  logic          clk,
   input  logic          reset,
   spi_master_if.master  bus
);
   localparam int               CNT_W     = $clog2(2*DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2*DATA_W - 1);

   spi_state_t        state_q, state_d;
   spi_mode_t         mode_q;
   logic [DATA_W-1:0] tx_q, rx_q, data_q;
   logic [CNT_W-1:0]  edge_cnt;
   logic              sclk_q, mosi_q, ss_q, busy_q, done_q;
   logic              tick, accept, shift_tick, leading, last_edge;
   logic              sample_en, shift_en;

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk_sys (clk),
      .rst_b   (reset),
      .en      (state_q != IDLE),
      .clr     (accept),
      .tick    (tick)
   );

   assign accept     = (state_q == IDLE) && bus.start;
   assign shift_tick = (state_q == SHIFT) && tick;
   // edge_cnt holds edges already made, so an even count means the next edge is leading
   assign leading    = ~edge_cnt[0];
   assign last_edge  = (edge_cnt == LAST_EDGE);
   assign sample_en  = shift_tick && (leading ^ mode_q.cpha);
   assign shift_en   = shift_tick && (mode_q.cpha ? leading : (!leading && !last_edge));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start)          state_d = LEAD;
         LEAD:    if (tick)               state_d = SHIFT;
         SHIFT:   if (tick && last_edge)  state_d = TRAIL;
         TRAIL:   if (tick)               state_d = DONE;
         DONE:                            state_d = IDLE;
         default:                         state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q   <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         data_q   <= '0;
         edge_cnt <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         ss_q     <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            mode_q   <= bus.mode;
            sclk_q   <= bus.mode[CPOL_BIT];
            ss_q     <= 1'b0;
            busy_q   <= 1'b1;
            edge_cnt <= '0;
            rx_q     <= '0;
            // CPHA=0 puts the MSB on the wire before the first edge
            if (!bus.mode[CPHA_BIT]) begin
               mosi_q <= bus.master_in[DATA_W-1];
               tx_q   <= bus.master_in << 1;
            end else begin
               tx_q   <= bus.master_in;
            end
         end
         if (shift_tick) begin
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + 1'b1;
         end
         if (sample_en) begin
            rx_q <= {rx_q[DATA_W-2:0], bus.miso};
         end
         if (shift_en) begin
            mosi_q <= tx_q[DATA_W-1];
            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
         end
         if ((state_q == TRAIL) && tick) begin
            ss_q <= 1'b1;
         end
         if (state_q == DONE) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            data_q <= rx_q;
         end
      end
   end

   assign bus.sclk        = sclk_q;
   assign bus.mosi        = mosi_q;
   assign bus.ss          = ss_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.master_data = data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural slave, pin-tie loopback, abort, back-to-back and wide config.
module tb_spi_master;
   import spi_pkg::*;

   localparam int W  = 8;
   localparam int D  = 2;
   localparam int W2 = 16;
   localparam int D2 = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   spi_master_if #(.DATA_W(W))  bus ();
   spi_master_if #(.DATA_W(W2)) bus2 ();

   spi_master #(.DATA_W(W), .CLK_DIV(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   spi_master #(.DATA_W(W2), .CLK_DIV(D2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   // behavioural slave: shifts its word out and captures mosi on the mode-defined edges
   logic         use_slave;
   logic         slave_miso;
   logic [W-1:0] s_sh, slave_data;
   logic [1:0]   s_mode;
   int           s_cnt;

   assign bus.miso  = use_slave ? slave_miso : bus.mosi;
   assign bus2.miso = bus2.mosi;

   always @(bus.sclk) begin
      if (!bus.ss && (s_cnt != 0 || bus.sclk != s_mode[1])) begin
         s_cnt = s_cnt + 1;
         if ((bus.sclk != s_mode[1]) != s_mode[0]) begin
            slave_data = {slave_data[W-2:0], bus.mosi};
         end else begin
            slave_miso = s_sh[W-1];
            s_sh       = s_sh << 1;
         end
      end
   end

   function automatic int exp_lat(input int w, input int d);
      return (2*w + 2)*d + 1;
   endfunction

   // Caller is #1 after a rising edge; returns #1 after the edge where done was seen.
   task automatic xfer(input logic [1:0] m, input logic [W-1:0] din,
                       output logic [W-1:0] dout, output int lat, output int trans,
                       output logic sc_first, output logic sc_last);
      logic prev;
      bus.mode      = m;
      bus.master_in = din;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.mode      = 2'($urandom);
      bus.master_in = W'($urandom);
      sc_first = bus.sclk;
      prev     = bus.sclk;
      trans    = 0;
      lat      = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (bus.sclk !== prev) trans++;
         prev = bus.sclk;
         if (bus.done === 1'b1) begin
            lat = n;
            break;
         end
      end
      dout    = bus.master_data;
      sc_last = bus.sclk;
   endtask

   task automatic slave_setup(input logic [1:0] m, input logic [W-1:0] ext);
      s_mode     = m;
      s_cnt      = 0;
      slave_data = '0;
      s_sh       = ext;
      if (!m[0]) begin
         slave_miso = s_sh[W-1];
         s_sh       = s_sh << 1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      n_vec++;
      if ({bus.ss, bus.sclk, bus.mosi, bus.busy, bus.done, bus.master_data} !== {5'b10000, 8'h00}) begin
         n_err++;
         $display("FAIL reset_w8 got ss/sclk/mosi/busy/done/data=%b/%b/%b/%b/%b/%h want 1/0/0/0/0/00",
                  bus.ss, bus.sclk, bus.mosi, bus.busy, bus.done, bus.master_data);
      end
      n_vec++;
      if ({bus2.ss, bus2.sclk, bus2.mosi, bus2.busy, bus2.done, bus2.master_data} !== {5'b10000, 16'h0000}) begin
         n_err++;
         $display("FAIL reset_w16 got ss/sclk/busy/done/data=%b/%b/%b/%b/%h want 1/0/0/0/0000",
                  bus2.ss, bus2.sclk, bus2.busy, bus2.done, bus2.master_data);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_slave_loopback();
      logic [W-1:0] din, ext, dout;
      logic [1:0]   m;
      int           lat, trans;
      logic         a, b;
      use_slave = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m   = (i < 4) ? 2'(i) : 2'($urandom);
         din = (i < 4) ? 8'b00110110 : W'($urandom);
         ext = (i < 4) ? 8'b11011010 : W'($urandom);
         slave_setup(m, ext);
         xfer(m, din, dout, lat, trans, a, b);
         n_vec++;
         if (dout !== ext) begin
            n_err++;
            $display("FAIL slave_master_data mode=%b got %h want %h", m, dout, ext);
         end
         n_vec++;
         if (slave_data !== din) begin
            n_err++;
            $display("FAIL slave_data mode=%b got %h want %h", m, slave_data, din);
         end
         n_vec++;
         if (lat != exp_lat(W, D)) begin
            n_err++;
            $display("FAIL slave_latency mode=%b got %0d want %0d", m, lat, exp_lat(W, D));
         end
         @(posedge clk); #1;
      end
      use_slave = 1'b0;
   endtask

   task automatic test_pin_tie();
      logic [W-1:0] din, dout;
      logic [1:0]   m;
      int           lat, trans;
      logic         sc_first, sc_last;
      for (int i = 0; i < 8; i++) begin
         m   = (i < 4) ? 2'(i) : 2'($urandom);
         din = (i < 4) ? 8'hA5 : W'($urandom);
         xfer(m, din, dout, lat, trans, sc_first, sc_last);
         n_vec++;
         if (dout !== din) begin
            n_err++;
            $display("FAIL tie_data mode=%b got %h want %h", m, dout, din);
         end
         n_vec++;
         if (trans != 2*W) begin
            n_err++;
            $display("FAIL tie_edges mode=%b got %0d want %0d", m, trans, 2*W);
         end
         n_vec++;
         if ({sc_first, sc_last} !== {m[1], m[1]}) begin
            n_err++;
            $display("FAIL tie_sclk_idle mode=%b got start/end %b/%b want %b", m, sc_first, sc_last, m[1]);
         end
         @(posedge clk); #1;
         n_vec++;
         if ({bus.sclk, bus.ss, bus.busy} !== {m[1], 2'b10}) begin
            n_err++;
            $display("FAIL tie_idle_level mode=%b got sclk/ss/busy %b/%b/%b want %b/1/0",
                     m, bus.sclk, bus.ss, bus.busy, m[1]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic [W-1:0] d1, d2;
      int           n_done, first;
      d1 = W'($urandom);
      d2 = ~d1;
      bus.mode      = 2'($urandom);
      bus.master_in = d1;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_done = 0;
      first  = -1;
      for (int n = 1; n <= 90; n++) begin
         if (n == 10) begin
            bus.start     = 1'b1;
            bus.master_in = d2;
         end
         @(posedge clk); #1;
         if (n == 10) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            n_done++;
            if (first < 0) first = n;
         end
      end
      n_vec++;
      if (n_done != 1) begin
         n_err++;
         $display("FAIL busy_start_dones got %0d want 1", n_done);
      end
      n_vec++;
      if (first != exp_lat(W, D)) begin
         n_err++;
         $display("FAIL busy_start_latency got %0d want %0d", first, exp_lat(W, D));
      end
      n_vec++;
      if (bus.master_data !== d1) begin
         n_err++;
         $display("FAIL busy_start_data got %h want %h", bus.master_data, d1);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] din, dout;
      int           lat, trans, n_done;
      logic         a, b;
      bus.mode      = 2'b00;
      bus.master_in = W'($urandom);
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      n_vec++;
      if ({bus.ss, bus.sclk, bus.busy, bus.done} !== 4'b1000) begin
         n_err++;
         $display("FAIL abort_levels got ss/sclk/busy/done %b/%b/%b/%b want 1/0/0/0",
                  bus.ss, bus.sclk, bus.busy, bus.done);
      end
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b1;
      n_done = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) n_done++;
      end
      n_vec++;
      if (n_done != 0) begin
         n_err++;
         $display("FAIL abort_no_done got %0d done pulses want 0", n_done);
      end
      din = W'($urandom);
      xfer(2'($urandom), din, dout, lat, trans, a, b);
      n_vec++;
      if ({dout, 8'(lat)} !== {din, 8'(exp_lat(W, D))}) begin
         n_err++;
         $display("FAIL abort_fresh got data=%h lat=%0d want data=%h lat=%0d", dout, lat, din, exp_lat(W, D));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] vals [3];
      int           dt [3];
      int           nd;
      vals = '{8'h01, 8'h80, 8'hFF};
      nd   = 0;
      bus.mode      = 2'($urandom);
      bus.master_in = vals[0];
      bus.start     = 1'b1;
      @(posedge clk); #1;
      for (int n = 1; n <= 200 && nd < 3; n++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            dt[nd] = n;
            n_vec++;
            if (bus.master_data !== vals[nd]) begin
               n_err++;
               $display("FAIL b2b_data word=%0d got %h want %h", nd, bus.master_data, vals[nd]);
            end
            n_vec++;
            if (bus.ss !== 1'b1) begin
               n_err++;
               $display("FAIL b2b_ss_gap word=%0d got ss=%b want 1", nd, bus.ss);
            end
            nd++;
            if (nd < 3) bus.master_in = vals[nd];
            else        bus.start     = 1'b0;
         end
      end
      bus.start = 1'b0;
      n_vec++;
      if (nd != 3) begin
         n_err++;
         $display("FAIL b2b_count got %0d done pulses want 3", nd);
      end else begin
         n_vec++;
         if ({dt[0], dt[1] - dt[0], dt[2] - dt[1]} !== {exp_lat(W, D), exp_lat(W, D) + 1, exp_lat(W, D) + 1}) begin
            n_err++;
            $display("FAIL b2b_spacing got %0d/+%0d/+%0d want %0d/+%0d/+%0d", dt[0], dt[1] - dt[0],
                     dt[2] - dt[1], exp_lat(W, D), exp_lat(W, D) + 1, exp_lat(W, D) + 1);
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_wide();
      logic [W2-1:0] din;
      int            lat;
      for (int i = 0; i < 3; i++) begin
         din = (i == 0) ? 16'hBEEF : W2'($urandom);
         bus2.mode      = 2'($urandom);
         bus2.master_in = din;
         bus2.start     = 1'b1;
         @(posedge clk); #1;
         bus2.start     = 1'b0;
         bus2.master_in = ~din;
         lat = -1;
         for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (bus2.done === 1'b1) begin
               lat = n;
               break;
            end
         end
         n_vec++;
         if (bus2.master_data !== din) begin
            n_err++;
            $display("FAIL wide_data got %h want %h", bus2.master_data, din);
         end
         n_vec++;
         if (lat != exp_lat(W2, D2)) begin
            n_err++;
            $display("FAIL wide_latency got %0d want %0d", lat, exp_lat(W2, D2));
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      use_slave      = 1'b0;
      slave_miso     = 1'b0;
      s_mode         = 2'b00;
      s_cnt          = 0;
      s_sh           = '0;
      slave_data     = '0;
      bus.mode       = 2'b00;
      bus.master_in  = '0;
      bus.start      = 1'b0;
      bus2.mode      = 2'b00;
      bus2.master_in = '0;
      bus2.start     = 1'b0;
      test_reset();
      test_pin_tie();
      test_slave_loopback();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
